// File: rtl/ttab_sweeper.sv
// ttab_sweeper: drives x through 0..1023, samples the DUT output y_in and streams ON-set minterms.
// Define TTAB_SIG_EN to add the sig output (XOR signature of every accepted minterm).
module ttab_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  x,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [9:0]  m_data,
  output logic [10:0] onset_count
`ifdef TTAB_SIG_EN
  ,
  output logic [9:0]  sig
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [9:0]  X_LAST      = 10'd1023;
  localparam logic [10:0] ONSET_MAX   = 11'd1024;

  state_t      state_r;
  logic [3:0]  settle_cnt_r;
  logic        sweep_start_s;
  logic        emit_hs_s;
  logic        last_vec_s;
  logic [9:0]  x_next_s;
  logic [10:0] onset_next_s;

  // Transition conditions shared by the FSM and the signature register.
  always_comb begin
    sweep_start_s = (state_r == IDLE) && start;
    emit_hs_s     = (state_r == EMIT) && m_ready;
    last_vec_s    = (x == X_LAST);
    x_next_s      = x + 10'd1;
    if (onset_count == ONSET_MAX) begin
      onset_next_s = onset_count;
    end else begin
      onset_next_s = onset_count + 11'd1;
    end
  end

  // Sweep FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= 4'd0;
      x            <= 10'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= 10'd0;
      onset_count  <= 11'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done    <= 1'b0;
          m_valid <= 1'b0;
          if (sweep_start_s) begin
            x            <= 10'd0;
            onset_count  <= 11'd0;
            settle_cnt_r <= 4'd0;
            busy         <= 1'b1;
            state_r      <= DRIVE;
          end else begin
            busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_r <= 4'd0;
            state_r      <= SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        SAMPLE: begin
          if (y_in) begin
            m_data      <= x;
            onset_count <= onset_next_s;
            m_valid     <= 1'b1;
            state_r     <= EMIT;
          end else if (last_vec_s) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            x       <= x_next_s;
            state_r <= DRIVE;
          end
        end
        EMIT: begin
          // m_data is untouched here, so it stays stable through any stall.
          if (emit_hs_s) begin
            m_valid <= 1'b0;
            if (last_vec_s) begin
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              x       <= x_next_s;
              state_r <= DRIVE;
            end
          end else begin
            m_valid <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          m_valid <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef TTAB_SIG_EN
  function automatic logic [9:0] sig_fold(input logic [9:0] acc, input logic [9:0] term);
    return acc ^ term;
  endfunction

  // Running XOR of every minterm the consumer accepts during the current sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 10'd0;
    end else if (sweep_start_s) begin
      sig <= 10'd0;
    end else if (emit_hs_s) begin
      sig <= sig_fold(sig, m_data);
    end else begin
      sig <= sig;
    end
  end
`endif

endmodule

// File: doc/ttab_sweeper.md
TTAB_SWEEPER -- requirements
Module: ttab_sweeper

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, legal range 1..15; cycles each input vector is held before the DUT output is sampled.
REQ-002 The block SHALL have these ports, clock and reset first:
  clk  input  1  rising-edge clock.
  rst  input  1  synchronous reset, active-high.
  start  input  1  one-cycle request to begin a sweep.
  x  output  10  vector driven onto DUT inputs x0..x9; x[0] drives x0.
  y_in  input  1  DUT output y0, combinational from x.
  busy  output  1  high from sweep start until DONE is left.
  done  output  1  one-cycle pulse when the sweep completes.
  m_valid  output  1  ON-set minterm available.
  m_ready  input  1  consumer accepts the minterm.
  m_data  output  10  ON-set minterm (value of x when y_in was 1).
  onset_count  output  11  number of ON-set minterms found, 0..1024.
  sig  output  10  XOR of all emitted minterms; present only with TTAB_SIG_EN.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset (clk, rst).

Function
REQ-004 FSM states SHALL be IDLE, DRIVE, SAMPLE, EMIT and DONE.
REQ-005 In IDLE with start=1, the FSM SHALL clear x, onset_count and sig to 0 and go to DRIVE.
REQ-006 In DRIVE, x SHALL be held for exactly SETTLE cycles and the FSM SHALL then go to SAMPLE.
REQ-007 In SAMPLE (one cycle), y_in SHALL be registered:
  - y_in=1: load m_data=x, increment onset_count, go to EMIT.
  - y_in=0: go to the advance step.
REQ-008 In EMIT, m_valid SHALL be 1.
  - m_data SHALL stay stable until m_valid and m_ready are both 1 on the same edge.
  - On that edge, the FSM SHALL take the advance step.
  - m_ready may be high before m_valid; an already-high m_ready completes the handshake in the first EMIT cycle.
REQ-009 Advance step: if x=1023, go to DONE; otherwise x SHALL increment by 1 and the FSM SHALL go to DRIVE.
  - x SHALL never wrap to 0 within a sweep.
REQ-010 DONE SHALL last one cycle with done=1, then return to IDLE.
  - x, onset_count and sig SHALL hold their final values until the next start.
REQ-011 busy SHALL be 1 in DRIVE, SAMPLE, EMIT and DONE, and 0 in IDLE.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 m_valid SHALL be 0 in every state except EMIT.
REQ-014 Sweep timing (start sampled on edge 0):
  - Each OFF-set vector SHALL take SETTLE+1 cycles.
  - Each ON-set vector SHALL take SETTLE+2 cycles plus any m_ready stall cycles.
  - done SHALL be high in the cycle after the last vector's final cycle.
REQ-015 onset_count SHALL saturate arithmetically at 1024 (11 bits); overflow is impossible.
REQ-016 All outputs SHALL be registered; no combinational path SHALL exist from y_in or m_ready to any output.

Reset
REQ-017 When rst=1 on an edge, the FSM SHALL go to IDLE and all outputs SHALL be 0:
  - x=0, busy=0, done=0, m_valid=0, m_data=0, onset_count=0, sig=0.
REQ-018 Reset mid-sweep (including in EMIT with m_valid=1) SHALL abandon the sweep; no done pulse SHALL follow.
REQ-019 rst SHALL take priority over start when both are 1 on the same edge.

Configuration
REQ-020 With macro TTAB_SIG_EN defined:
  - sig SHALL be updated to sig XOR m_data on each EMIT handshake edge.
  - sig SHALL be cleared at sweep start and by reset.
REQ-021 Without TTAB_SIG_EN, the sig port and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-022 DUT y=0, SETTLE=1, start at edge 0 -> m_valid never 1; done high in cycle 2049; onset_count=0; x=1023.
REQ-023 DUT y=1, m_ready tied 1, SETTLE=1 -> 1024 beats with m_data 0,1,...,1023 in order; onset_count=1024; done in cycle 3073; with TTAB_SIG_EN, sig=0.
REQ-024 DUT y=(x==5)|(x==9), m_ready low for 5 cycles on the first beat -> m_valid and m_data=5 stable for 6 cycles; second beat m_data=9; onset_count=2; with TTAB_SIG_EN, sig=12.
REQ-025 rst asserted for 1 cycle while in EMIT at x=300 -> next cycle all outputs 0, FSM in IDLE, no done; a new start then sweeps from x=0.
REQ-026 start pulsed repeatedly mid-sweep, SETTLE=3 -> ignored; each OFF-set vector takes 4 cycles; exactly one done pulse.
